app_payload_gen: RTL and testbench
==================================

# app_payload_gen

Parametrised application-payload generator feeding the UDP/TCP send path (`send_top`) in the `clk_32` domain. It emits bursts of fixed-length packets on a valid/last word stream with a per-packet byte length and op code. Payload can be an incrementing count, a constant, or a PRBS. Packet count, inter-packet gap and payload length are runtime-configurable, replacing the fixed 64-word memory-backed generator.

## Interface
Parameters:
- `DATA_W`, 32: payload word width; a multiple of 8.
- `MAX_WORDS`, 256: maximum words per packet.
- `GAP_W`, 8: width of the inter-packet gap counter.
- `CNT_W`, 16: width of the packet counter.

Ports:
- `clk_32`  in  1  system clock.
- `reset_32`  in  1  asynchronous, active-high reset.
- `start`  in  1  a rising edge (registered) starts a run.
- `stop`  in  1  level; ends the run after the current packet.
- `cfg_mode`  in  2  payload mode: 0 incrementing, 1 constant, 2 PRBS, 3 treated as 0.
- `cfg_len_words`  in  clog2(MAX_WORDS)+1  words per packet; 0 is treated as 1; values above MAX_WORDS are clamped to MAX_WORDS.
- `cfg_gap`  in  GAP_W  idle cycles inserted after each packet.
- `cfg_num_pkts`  in  CNT_W  packets per run; 0 means continuous.
- `cfg_seed`  in  DATA_W  start value or constant.
- `cfg_op`  in  2  op code forwarded to `send_top` (1 UDP, 2 TCP).
- `sink_ready`  in  1  downstream ready, sampled only before each packet.
- `data_out`  out  DATA_W  payload word.
- `data_valid`  out  1  word valid.
- `data_last`  out  1  last word of the packet.
- `data_length`  out  16  packet length in bytes.
- `op_out`  out  2  latched `cfg_op`.
- `busy`  out  1  high when the FSM is not IDLE.
- `pkt_count`  out  CNT_W  packets sent in the current run.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- All `cfg_*` inputs are latched on the start edge and ignored for the rest of the run.
- States:
  - IDLE: on a start rising edge, latch config, clear `pkt_count`, load the pattern generator, go to WAIT_RDY.
  - WAIT_RDY: if `stop` is high, go to IDLE. Otherwise, if `sink_ready` is high, go to SEND.
  - SEND: emit exactly len words, one per cycle, with no backpressure. On the last word, increment `pkt_count`. Then:
    - if `stop` was seen during the packet, or the `cfg_num_pkts` target is reached, go to IDLE;
    - else if gap > 0, go to GAP;
    - else go to WAIT_RDY.
  - GAP: count `cfg_gap` cycles, then go to WAIT_RDY. If `stop` is high during GAP, go to IDLE.
- Payload rules:
  - Incrementing: word k of the run = seed + k, modulo 2^DATA_W. The count continues across packets.
  - Constant: every word = seed.
  - PRBS: Galois LFSR using the low 32 bits, polynomial 0x80200003. A seed of 0 is replaced by 1. The LFSR advances one step per word and continues across packets. For DATA_W > 32, the 32-bit value is replicated.
- `data_length` = len × DATA_W/8, truncated to 16 bits.
- `stop` is sticky within a packet: a pulse of any length during SEND ends the run after `data_last`.
- `done` pulses on every transition into IDLE from a non-IDLE state.
- A start edge while `busy` is high is ignored.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `data_last`=0, `data_length`=0, `op_out`=0, `busy`=0, `pkt_count`=0, `done`=0; FSM in IDLE; `start` edge register cleared.
- Reset asserted mid-packet drops all outputs to their reset values immediately, with no trailing `data_last`.
- All outputs are registered.
- Start latency: `start` sampled high at edge E0 (low at E-1) gives WAIT_RDY at E1. If `sink_ready` is high at E1, the first `data_valid` is at E2.
- `data_valid` is high for exactly len consecutive cycles. `data_last` is coincident with the final word.
- When len = 1, `data_valid` and `data_last` are high in the same cycle.
- `data_length` and `op_out` are stable from the first through the last word.
- Minimum inter-packet idle is `cfg_gap` + 1 cycles, plus one cycle per extra cycle spent waiting on `sink_ready`.
- `pkt_count` updates on the cycle after `data_last`. It wraps modulo 2^CNT_W in continuous mode.
- `done` asserts on the cycle `busy` falls.

## Configuration
- `PAYLOAD_GEN_SEQNUM_EN`:
  - Defined: word 0 of every packet is replaced by the packet sequence number, zero-extended `pkt_count` before increment, starting at 0. The pattern generator does not advance for that word, so the pattern stream is identical to the undefined case, shifted.
  - Undefined: every word comes from the pattern generator.

## Test plan
- Incrementing run: mode 0, seed 0x100, len 4, gap 2, num 3, ready=1 → 12 words 0x100..0x10B. `data_last` on words 4, 8 and 12. 3 idle cycles between packets. `data_length`=16, `pkt_count`=3, `done` one pulse.
- Ready hold-off: `sink_ready`=0 for 10 cycles after start → no `data_valid`. The first word appears two cycles after ready is sampled high.
- PRBS: mode 2, seed 0 → the first word is the LFSR step from 1. The 40-word sequence matches the reference model.
- Stop mid-packet: num=0, len 8, `stop` pulsed on word 3 → the packet completes all 8 words, then IDLE with `done`.
- Edge cases: len 0 → single word with `data_valid` and `data_last` together, `data_length`=4. `start` re-pulsed while busy → no effect.
- Reset mid-packet, plus `PAYLOAD_GEN_SEQNUM_EN`: all outputs read 0 on the next cycle. With the macro defined, word 0 values are 0, 1, 2 across packets.

Source files
------------

// File: rtl/app_payload_gen_if.sv
// app_payload_gen_if: configuration, control and payload stream bundle of the payload generator.
// Ports: master = generator side (drives data_*, op_out, busy, pkt_count, done);
//        slave  = control/sink side (drives start, stop, cfg_*, sink_ready).
interface app_payload_gen_if #(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 256,
  parameter int GAP_W     = 8,
  parameter int CNT_W     = 16
);
  localparam int LEN_W = $clog2(MAX_WORDS) + 1;

  // control / configuration
  logic              start;
  logic              stop;
  logic [1:0]        cfg_mode;
  logic [LEN_W-1:0]  cfg_len_words;
  logic [GAP_W-1:0]  cfg_gap;
  logic [CNT_W-1:0]  cfg_num_pkts;
  logic [DATA_W-1:0] cfg_seed;
  logic [1:0]        cfg_op;
  logic              sink_ready;

  // payload stream and status
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_last;
  logic [15:0]       data_length;
  logic [1:0]        op_out;
  logic              busy;
  logic [CNT_W-1:0]  pkt_count;
  logic              done;

  modport master (
    input  start, stop, cfg_mode, cfg_len_words, cfg_gap, cfg_num_pkts, cfg_seed, cfg_op, sink_ready,
    output data_out, data_valid, data_last, data_length, op_out, busy, pkt_count, done
  );

  modport slave (
    output start, stop, cfg_mode, cfg_len_words, cfg_gap, cfg_num_pkts, cfg_seed, cfg_op, sink_ready,
    input  data_out, data_valid, data_last, data_length, op_out, busy, pkt_count, done
  );
endinterface

// File: rtl/app_payload_gen.sv
// app_payload_gen: burst packet generator (incrementing / constant / PRBS payload) for the send path.
// Ports: clk_32, reset_32 (async, active-high); gen = app_payload_gen_if.master (cfg/control in, stream/status out).
// Option: define PAYLOAD_GEN_SEQNUM_EN to replace word 0 of each packet with the packet sequence number.
module app_payload_gen #(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 256,
  parameter int GAP_W     = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk_32,
  input  logic             reset_32,
  app_payload_gen_if.master gen
);
  localparam int          LEN_W = $clog2(MAX_WORDS) + 1;
  localparam logic [31:0] POLY  = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, WAIT_RDY, SEND, GAP} state_t;

  state_t            state_q;
  logic              start_q;
  logic [1:0]        mode_q;
  logic [LEN_W-1:0]  len_q;
  logic [GAP_W-1:0]  gap_q, gcnt_q;
  logic [CNT_W-1:0]  num_q, pkt_count_q;
  logic [DATA_W-1:0] seed_q, cnt_q, data_out_q;
  logic [31:0]       lfsr_q;
  logic [LEN_W-1:0]  wcnt_q;
  logic              stop_seen_q;
  logic              data_valid_q, data_last_q, busy_q, done_q;
  logic [15:0]       data_length_q;
  logic [1:0]        op_out_q;

  logic              start_rise;
  logic [LEN_W-1:0]  len_d;
  logic [31:0]       seed32_d;
  logic [31:0]       lfsr_d;
  logic              last_word;
  logic              target_hit;
  logic              seq_slot;
  logic [DATA_W-1:0] word_d;

  // 32-bit PRBS value spread across the whole data word
  function automatic logic [DATA_W-1:0] rep32(input logic [31:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[i % 32];
    return r;
  endfunction

  always_comb begin
    start_rise = gen.start & ~start_q;

    len_d = gen.cfg_len_words;
    if (gen.cfg_len_words == '0)
      len_d = LEN_W'(1);
    else if (gen.cfg_len_words > LEN_W'(MAX_WORDS))
      len_d = LEN_W'(MAX_WORDS);

    seed32_d = 32'(gen.cfg_seed);
    if (seed32_d == 32'h0) seed32_d = 32'h1;  // all-zero LFSR would lock up

    // Galois, right-shifting
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);

    last_word  = (wcnt_q == len_q - LEN_W'(1));
    // pkt_count_q has not yet counted the packet now finishing
    target_hit = (num_q != '0) && ((pkt_count_q + CNT_W'(1)) == num_q);

`ifdef PAYLOAD_GEN_SEQNUM_EN
    seq_slot = (wcnt_q == '0);
`else
    seq_slot = 1'b0;
`endif

    case (mode_q)
      2'd1:    word_d = seed_q;
      2'd2:    word_d = rep32(lfsr_d);
      default: word_d = cnt_q;
    endcase
    if (seq_slot) word_d = DATA_W'(pkt_count_q);
  end

  always_ff @(posedge clk_32 or posedge reset_32) begin
    if (reset_32) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      mode_q        <= '0;
      len_q         <= '0;
      gap_q         <= '0;
      gcnt_q        <= '0;
      num_q         <= '0;
      pkt_count_q   <= '0;
      seed_q        <= '0;
      cnt_q         <= '0;
      lfsr_q        <= '0;
      wcnt_q        <= '0;
      stop_seen_q   <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      data_last_q   <= 1'b0;
      data_length_q <= '0;
      op_out_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      start_q      <= gen.start;
      done_q       <= 1'b0;
      data_valid_q <= 1'b0;
      data_last_q  <= 1'b0;
      // count lands one cycle after data_last
      if (data_last_q) pkt_count_q <= pkt_count_q + CNT_W'(1);

      case (state_q)
        IDLE: begin
          if (start_rise) begin
            mode_q        <= gen.cfg_mode;
            len_q         <= len_d;
            gap_q         <= gen.cfg_gap;
            num_q         <= gen.cfg_num_pkts;
            seed_q        <= gen.cfg_seed;
            cnt_q         <= gen.cfg_seed;
            lfsr_q        <= seed32_d;
            data_length_q <= 16'(32'(len_d) * 32'(DATA_W / 8));
            op_out_q      <= gen.cfg_op;
            pkt_count_q   <= '0;
            busy_q        <= 1'b1;
            state_q       <= WAIT_RDY;
          end
        end

        WAIT_RDY: begin
          if (gen.stop) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (gen.sink_ready) begin
            wcnt_q      <= '0;
            stop_seen_q <= 1'b0;
            state_q     <= SEND;
          end
        end

        SEND: begin
          data_valid_q <= 1'b1;
          data_out_q   <= word_d;
          data_last_q  <= last_word;
          wcnt_q       <= wcnt_q + LEN_W'(1);
          stop_seen_q  <= stop_seen_q | gen.stop;
          if (!seq_slot) begin
            cnt_q  <= cnt_q + DATA_W'(1);
            lfsr_q <= lfsr_d;
          end
          if (last_word) begin
            if (stop_seen_q || gen.stop || target_hit) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else if (gap_q != '0) begin
              gcnt_q  <= gap_q;
              state_q <= GAP;
            end else begin
              state_q <= WAIT_RDY;
            end
          end
        end

        GAP: begin
          if (gen.stop) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (gcnt_q == GAP_W'(1)) begin
            state_q <= WAIT_RDY;
          end else begin
            gcnt_q <= gcnt_q - GAP_W'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign gen.data_out    = data_out_q;
  assign gen.data_valid  = data_valid_q;
  assign gen.data_last   = data_last_q;
  assign gen.data_length = data_length_q;
  assign gen.op_out      = op_out_q;
  assign gen.busy        = busy_q;
  assign gen.pkt_count   = pkt_count_q;
  assign gen.done        = done_q;
endmodule

// File: tb/tb_app_payload_gen.sv
// tb_app_payload_gen: scoreboard bench for app_payload_gen (expected words queued at start, popped per valid word).
// Covers reset values, incrementing/constant/PRBS payloads, ready hold-off, stop, len 0 / clamp, restart-while-busy, reset mid-packet.
module tb_app_payload_gen;
  logic clk_32   = 1'b0;
  logic reset_32 = 1'b1;

  always #5 clk_32 = ~clk_32;

  app_payload_gen_if #(.DATA_W(32), .MAX_WORDS(256), .GAP_W(8), .CNT_W(16)) bus ();

  app_payload_gen #(.DATA_W(32), .MAX_WORDS(256), .GAP_W(8), .CNT_W(16)) dut (
    .clk_32   (clk_32),
    .reset_32 (reset_32),
    .gen      (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int nvalid   = 0;
  int idle_run = 0;
  int exp_idle = -1;
  bit seen_last = 0;
  logic [15:0] exp_bytes = '0;
  logic [1:0]  exp_op    = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // reference payload for one run
  task automatic push_run(input int mode, input logic [31:0] seed, input int len, input int npk);
    int          el;
    logic [31:0] cnt, lf, w;
    exp_t        e;
    el  = (len == 0) ? 1 : ((len > 256) ? 256 : len);
    cnt = seed;
    lf  = (seed == 32'h0) ? 32'h1 : seed;
    for (int p = 0; p < npk; p++) begin
      for (int k = 0; k < el; k++) begin
`ifdef PAYLOAD_GEN_SEQNUM_EN
        if (k == 0) begin
          w = 32'(p);
        end else
`endif
        begin
          lf = lstep(lf);
          case (mode)
            1:       w = seed;
            2:       w = lf;
            default: w = cnt;
          endcase
          cnt = cnt + 32'd1;
        end
        e.d = w;
        e.l = (k == el - 1);
        sb.push_back(e);
      end
    end
  endtask

  // stream monitor / scoreboard consumer
  always @(negedge clk_32) begin
    exp_t e;
    if (reset_32) begin
      seen_last = 0;
      idle_run  = 0;
    end else begin
      if (bus.data_valid) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("word", 64'(bus.data_out), 64'(e.d));
          check("last", 64'(bus.data_last), 64'(e.l));
        end
        check("length", 64'(bus.data_length), 64'(exp_bytes));
        check("op", 64'(bus.op_out), 64'(exp_op));
        if (seen_last && exp_idle >= 0) check("idle_gap", 64'(idle_run), 64'(exp_idle));
        seen_last = bus.data_last;
        idle_run  = 0;
        nvalid++;
      end else begin
        idle_run++;
      end
      if (bus.done) begin
        done_cnt++;
        check("done_busy_low", 64'(bus.busy), 64'd0);
        seen_last = 0;
      end
    end
  end

  task automatic set_cfg(input int mode, input logic [31:0] seed, input int len, input int gap,
                         input int num, input int op);
    bus.cfg_mode      = 2'(mode);
    bus.cfg_seed      = seed;
    bus.cfg_len_words = 9'(len);
    bus.cfg_gap       = 8'(gap);
    bus.cfg_num_pkts  = 16'(num);
    bus.cfg_op        = 2'(op);
  endtask

  task automatic start_pulse();
    @(negedge clk_32);
    bus.start = 1'b1;
    @(negedge clk_32);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    bit got;
    got = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_32);
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    check("done_seen", 64'(got), 64'd1);
  endtask

  task automatic wait_words(input int n, input int maxc);
    int n0;
    bit got;
    n0  = nvalid;
    got = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_32);
      if (nvalid - n0 >= n) begin
        got = 1;
        break;
      end
    end
    check("words_seen", 64'(got), 64'd1);
  endtask

  initial begin
    int d0, nv;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.sink_ready = 1'b0;
    set_cfg(0, 32'h0, 1, 0, 1, 0);

    // reset values
    repeat (3) @(negedge clk_32);
    reset_32 = 1'b0;
    @(negedge clk_32);
    check("rst_data_out", 64'(bus.data_out), 64'd0);
    check("rst_valid", 64'(bus.data_valid), 64'd0);
    check("rst_last", 64'(bus.data_last), 64'd0);
    check("rst_length", 64'(bus.data_length), 64'd0);
    check("rst_op", 64'(bus.op_out), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_pkt_count", 64'(bus.pkt_count), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);

    // incrementing run, 3 packets of 4 words, gap 2
    set_cfg(0, 32'h100, 4, 2, 3, 1);
    exp_bytes = 16'd16; exp_op = 2'd1; exp_idle = 3;
    push_run(0, 32'h100, 4, 3);
    bus.sink_ready = 1'b1;
    d0 = done_cnt;
    start_pulse();
    check("busy_running", 64'(bus.busy), 64'd1);
    wait_done(200);
    repeat (5) @(negedge clk_32);
    check("inc_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("inc_pkt_count", 64'(bus.pkt_count), 64'd3);
    check("inc_sb_drained", 64'(sb.size()), 64'd0);

    // ready hold-off
    bus.sink_ready = 1'b0;
    set_cfg(1, 32'hA5A5_5A5A, 2, 0, 1, 2);
    exp_bytes = 16'd8; exp_op = 2'd2; exp_idle = -1;
    push_run(1, 32'hA5A5_5A5A, 2, 1);
    start_pulse();
    nv = 0;
    repeat (10) begin
      @(negedge clk_32);
      if (bus.data_valid) nv++;
    end
    check("holdoff_no_valid", 64'(nv), 64'd0);
    bus.sink_ready = 1'b1;
    @(negedge clk_32);
    check("ready_lat_1", 64'(bus.data_valid), 64'd0);
    @(negedge clk_32);
    check("ready_lat_2", 64'(bus.data_valid), 64'd1);
    wait_done(50);
    repeat (2) @(negedge clk_32);
    check("holdoff_pkt_count", 64'(bus.pkt_count), 64'd1);
    check("holdoff_sb_drained", 64'(sb.size()), 64'd0);

    // PRBS, seed 0, 4 packets of 10 words back to back
    set_cfg(2, 32'h0, 10, 0, 4, 1);
    exp_bytes = 16'd40; exp_op = 2'd1; exp_idle = 1;
    push_run(2, 32'h0, 10, 4);
    start_pulse();
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.data_valid) begin
        nv = 1;
        break;
      end
      @(negedge clk_32);
    end
    check("prbs_started", 64'(nv), 64'd1);
`ifndef PAYLOAD_GEN_SEQNUM_EN
    check("prbs_first", 64'(bus.data_out), 64'h8020_0003);
`endif
    wait_done(200);
    repeat (2) @(negedge clk_32);
    check("prbs_pkt_count", 64'(bus.pkt_count), 64'd4);
    check("prbs_sb_drained", 64'(sb.size()), 64'd0);

    // stop pulse mid-packet in continuous mode
    set_cfg(0, 32'h0, 8, 3, 0, 2);
    exp_bytes = 16'd32; exp_op = 2'd2; exp_idle = -1;
    push_run(0, 32'h0, 8, 1);
    start_pulse();
    wait_words(3, 50);
    bus.stop = 1'b1;
    @(negedge clk_32);
    bus.stop = 1'b0;
    wait_done(50);
    repeat (2) @(negedge clk_32);
    check("stop_pkt_count", 64'(bus.pkt_count), 64'd1);
    check("stop_sb_drained", 64'(sb.size()), 64'd0);
    check("stop_busy", 64'(bus.busy), 64'd0);

    // len 0 -> single-word packets; start re-pulsed while busy
    set_cfg(1, 32'h0000_CAFE, 0, 1, 2, 1);
    exp_bytes = 16'd4; exp_op = 2'd1; exp_idle = 2;
    push_run(1, 32'h0000_CAFE, 0, 2);
    start_pulse();
    repeat (2) @(negedge clk_32);
    check("busy_at_restart", 64'(bus.busy), 64'd1);
    start_pulse();
    wait_done(50);
    repeat (20) @(negedge clk_32);
    check("len0_pkt_count", 64'(bus.pkt_count), 64'd2);
    check("len0_sb_drained", 64'(sb.size()), 64'd0);
    check("len0_busy", 64'(bus.busy), 64'd0);

    // oversize length clamped to MAX_WORDS, incrementing wraps past 2^32
    set_cfg(0, 32'hFFFF_FFFE, 300, 0, 1, 2);
    exp_bytes = 16'd1024; exp_op = 2'd2; exp_idle = -1;
    push_run(0, 32'hFFFF_FFFE, 300, 1);
    start_pulse();
    wait_done(600);
    repeat (2) @(negedge clk_32);
    check("clamp_sb_drained", 64'(sb.size()), 64'd0);

    // reset in the middle of a packet
    set_cfg(0, 32'h50, 8, 0, 0, 2);
    exp_bytes = 16'd32; exp_op = 2'd2; exp_idle = -1;
    push_run(0, 32'h50, 8, 1);
    start_pulse();
    wait_words(3, 50);
    #2 reset_32 = 1'b1;
    #1;
    check("mid_rst_data_out", 64'(bus.data_out), 64'd0);
    check("mid_rst_valid", 64'(bus.data_valid), 64'd0);
    check("mid_rst_last", 64'(bus.data_last), 64'd0);
    check("mid_rst_length", 64'(bus.data_length), 64'd0);
    check("mid_rst_op", 64'(bus.op_out), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_pkt_count", 64'(bus.pkt_count), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    sb.delete();
    @(negedge clk_32);
    reset_32 = 1'b0;
    repeat (4) @(negedge clk_32);
    check("post_rst_valid", 64'(bus.data_valid), 64'd0);
    check("post_rst_busy", 64'(bus.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
